// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, instruction-memory addressing and IF/ID register.
// Optional hold-cycle counter enabled by defining FETCH_STALL_CNT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [31:0]       branch_addr,
  output logic [31:0]       imem_addr,
  input  logic [31:0]       imem_data,
  output logic [31:0]       id_pc,
  output logic [31:0]       id_instr,
  output logic              id_valid
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_count
`endif
);

  typedef enum logic [1:0] {
    ACT_ADVANCE,
    ACT_HOLD,
    ACT_REDIRECT
  } act_e;

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("fetch_stage: CNT_W must be at least 1");
  end

  act_e        act;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        id_valid_q, id_valid_d;
  logic        addr_lsb_unused;

  assign addr_lsb_unused = ^branch_addr[1:0];
  assign pc_plus4        = pc_q + 32'd4;

  // Redirect outranks freeze so a branch is never lost behind a hazard stall.
  always_comb begin
    act = ACT_ADVANCE;
    if (branch_taken) begin
      act = ACT_REDIRECT;
    end else if (freeze) begin
      act = ACT_HOLD;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    unique case (act)
      ACT_REDIRECT: begin
        pc_d       = {branch_addr[31:2], 2'b00};
        id_pc_d    = '0;
        id_instr_d = '0;
        id_valid_d = 1'b0;
      end
      ACT_HOLD: begin
      end
      default: begin
        pc_d       = pc_plus4;
        id_pc_d    = pc_plus4;
        id_instr_d = imem_data;
        id_valid_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_PC_ALIGNED;
      id_pc_q    <= '0;
      id_instr_q <= '0;
      id_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign imem_addr = pc_q;
  assign id_pc     = id_pc_q;
  assign id_instr  = id_instr_q;
  assign id_valid  = id_valid_q;

`ifdef FETCH_STALL_CNT_EN
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  // Saturating: sticks at all-ones until the next reset.
  always_comb begin
    stall_count_d = stall_count_q;
    if (act == ACT_HOLD && stall_count_q != '1) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: cycle-level reference model plus directed literal checks.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int unsigned CW     = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_valid;
  logic [CW-1:0] stall_count;

  int checks = 0;
  int failures = 0;
  bit done = 1'b0;

  fetch_stage #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .freeze(freeze),
    .branch_taken(branch_taken),
    .branch_addr(branch_addr),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .id_pc(id_pc),
    .id_instr(id_instr),
    .id_valid(id_valid)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_count(stall_count)
`endif
  );

`ifndef FETCH_STALL_CNT_EN
  assign stall_count = '0;
`endif

  always #5 clk = ~clk;

  // Instruction memory stub: a distinct word for every address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
  endfunction

  assign imem_data = mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the architectural PC and the decode-side view.
  logic [31:0] m_pc, m_id_pc, m_id_instr;
  logic        m_valid;
  int unsigned m_stalls;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc = RST_PC & 32'hFFFF_FFFC;
      m_id_pc = 0; m_id_instr = 0; m_valid = 0; m_stalls = 0;
    end else if (branch_taken) begin
      m_pc = branch_addr & 32'hFFFF_FFFC;
      m_id_pc = 0; m_id_instr = 0; m_valid = 0;
    end else if (freeze) begin
      if (m_stalls < (1 << CW) - 1) m_stalls++;
    end else begin
      m_id_instr = mem_word(m_pc);
      m_pc = m_pc + 32'd4;
      m_id_pc = m_pc;
      m_valid = 1;
    end
  end

  always @(negedge clk) begin
    if (!done) begin
      chk("cmp_imem_addr", imem_addr, m_pc);
      chk("cmp_id_pc", id_pc, m_id_pc);
      chk("cmp_id_instr", id_instr, m_id_instr);
      chk("cmp_id_valid", {31'b0, id_valid}, {31'b0, m_valid});
`ifdef FETCH_STALL_CNT_EN
      chk("cmp_stall_count", 32'(stall_count), m_stalls);
`endif
    end
  end

  task automatic step(input logic f, input logic b, input logic [31:0] a);
    freeze = f; branch_taken = b; branch_addr = a;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string name, input int unsigned exp);
`ifdef FETCH_STALL_CNT_EN
    chk(name, 32'(stall_count), exp);
`endif
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_id_valid", {31'b0, id_valid}, 32'h0);
    chk("rst_id_instr", id_instr, 32'h0);
    rst = 1'b1;

    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 0);
      chk("adv_imem_addr", imem_addr, 32'(4 * i));
      chk("adv_id_pc", id_pc, 32'(4 * i));
      chk("adv_id_instr", id_instr, mem_word(32'(4 * (i - 1))));
      chk("adv_id_valid", {31'b0, id_valid}, 32'h1);
    end

    step(1, 1, 32'h0000_0103);
    chk("brfrz_pc", imem_addr, 32'h0000_0100);
    chk("brfrz_valid", {31'b0, id_valid}, 32'h0);
    chk("brfrz_instr", id_instr, 32'h0);
    chk_cnt("brfrz_cnt", 0);

    step(0, 1, 32'h0000_0008);
    chk("br8_pc", imem_addr, 32'h8);
    for (int i = 1; i <= 6; i++) begin
      step(1, 0, 0);
      chk("frz_pc", imem_addr, 32'h8);
      chk("frz_bubble", {31'b0, id_valid}, 32'h0);
      chk_cnt("frz_cnt", (i < 3) ? i : 3);
    end
    step(0, 0, 0);
    chk("resume_pc", imem_addr, 32'hC);
    chk("resume_id_pc", id_pc, 32'hC);
    chk("resume_instr", id_instr, mem_word(32'h8));

    step(0, 1, 32'hFFFF_FFFE);
    chk("wrap_target", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0);
    chk("wrap_pc", imem_addr, 32'h0);
    chk("wrap_id_pc", id_pc, 32'h0);
    chk("wrap_valid", {31'b0, id_valid}, 32'h1);
    chk("wrap_instr", id_instr, mem_word(32'hFFFF_FFFC));

    freeze = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_imem_addr", imem_addr, 32'h0);
    chk("arst_id_pc", id_pc, 32'h0);
    chk("arst_id_instr", id_instr, 32'h0);
    chk("arst_id_valid", {31'b0, id_valid}, 32'h0);
    chk_cnt("arst_cnt", 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(0, 0, 0);
    chk("post_rst_pc", imem_addr, 32'h4);
    chk("post_rst_instr", id_instr, mem_word(32'h0));
    step(0, 0, 0);

    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
